// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binarised neural network layers.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } layer_state_t;

  // Layer-state codes used by the top-level controller.
  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_LOAD    = 3'd1,
    s_LAYER_1 = 3'd2,
    s_LAYER_2 = 3'd3,
    s_LAYER_3 = 3'd4
  } ctrl_state_t;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount of one CHUNK-bit slice; bits with valid_mask=0 never count.
module bnn_xnor_popcount #(
  parameter int CHUNK = 28,
  parameter int PC_W  = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] weight,
  input  logic [CHUNK-1:0] data,
  input  logic [CHUNK-1:0] valid_mask,
  output logic [PC_W-1:0]  count
);

  logic [CHUNK-1:0] hits;

  assign hits = ~(weight ^ data) & valid_mask;

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      count = count + PC_W'(hits[i]);
    end
  end

endmodule

// File: rtl/bnn_output_layer_seq.sv
// Time-multiplexed BNN output layer: per-class XNOR-popcount scores, CHUNK bits per cycle,
// with a running argmax (lowest index wins ties) reported through a start/busy/done handshake.
module bnn_output_layer_seq
  import bnn_pkg::*;
#(
  parameter int NUM_INPUTS  = 196,
  parameter int NUM_CLASSES = 10,
  parameter int CHUNK       = 28,
  parameter int CNT_W       = $clog2(NUM_INPUTS + 1),
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_INPUTS-1:0]          data_in,
  input  logic [NUM_INPUTS*NUM_CLASSES-1:0] weights_in,
  output logic                           busy,
  output logic                           done,
  output logic [IDX_W-1:0]               answer,
  output logic [CNT_W-1:0]               max_score,
  output logic [NUM_CLASSES*CNT_W-1:0]   class_scores
);

  localparam int unsigned CPC   = ceil_div(NUM_INPUTS, CHUNK);
  localparam int unsigned PAD_W = CPC * CHUNK;
  localparam int          CHK_W = (CPC > 1) ? $clog2(CPC) : 1;
  localparam int          PC_W  = $clog2(CHUNK + 1);

  layer_state_t state_q, state_d;

  logic [NUM_INPUTS-1:0] data_q;
  logic [CHK_W-1:0]      chunk_cnt;
  logic [IDX_W-1:0]      class_cnt;
  logic [CNT_W-1:0]      acc;
  logic [CNT_W-1:0]      best_score;
  logic [IDX_W-1:0]      best_idx;
  logic                  best_valid;

  logic [PAD_W-1:0] w_pad, d_pad, m_pad;
  logic [CHUNK-1:0] w_chunk, d_chunk, m_chunk;
  logic [PC_W-1:0]  pop;
  logic [CNT_W-1:0] acc_next;
  logic             upd;
  logic [CNT_W-1:0] win_score;
  logic [IDX_W-1:0] win_idx;
  logic             chunk_last, class_last;
  logic             accept, class_end, run_end;

  // Pad to a whole number of chunks; the mask keeps tail bits out of the count.
  always_comb begin
    w_pad = '0;
    d_pad = '0;
    m_pad = '0;
    w_pad[NUM_INPUTS-1:0] = weights_in[32'(class_cnt)*NUM_INPUTS +: NUM_INPUTS];
    d_pad[NUM_INPUTS-1:0] = data_q;
    m_pad[NUM_INPUTS-1:0] = '1;
  end

  assign w_chunk = w_pad[32'(chunk_cnt)*CHUNK +: CHUNK];
  assign d_chunk = d_pad[32'(chunk_cnt)*CHUNK +: CHUNK];
  assign m_chunk = m_pad[32'(chunk_cnt)*CHUNK +: CHUNK];

  bnn_xnor_popcount #(
    .CHUNK (CHUNK),
    .PC_W  (PC_W)
  ) u_popcount (
    .weight     (w_chunk),
    .data       (d_chunk),
    .valid_mask (m_chunk),
    .count      (pop)
  );

  assign acc_next   = acc + CNT_W'(pop);
  assign upd        = !best_valid || (acc_next > best_score);
  assign win_score  = upd ? acc_next : best_score;
  assign win_idx    = upd ? class_cnt : best_idx;
  assign chunk_last = (chunk_cnt == CHK_W'(CPC - 1));
  assign class_last = (class_cnt == IDX_W'(NUM_CLASSES - 1));

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start)   state_d = ACCUM;
      ACCUM:      if (run_end) state_d = DONE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    class_end = 1'b0;
    run_end   = 1'b0;
    unique case (state_q)
      IDLE, DONE: accept = start;
      ACCUM: begin
        class_end = chunk_last;
        run_end   = chunk_last && class_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q       <= '0;
      chunk_cnt    <= '0;
      class_cnt    <= '0;
      acc          <= '0;
      best_score   <= '0;
      best_idx     <= '0;
      best_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      answer       <= '0;
      max_score    <= '0;
      class_scores <= '0;
    end else if (accept) begin
      data_q       <= data_in;
      chunk_cnt    <= '0;
      class_cnt    <= '0;
      acc          <= '0;
      best_score   <= '0;
      best_idx     <= '0;
      best_valid   <= 1'b0;
      busy         <= 1'b1;
      done         <= 1'b0;
      class_scores <= '0;
    end else if (state_q == ACCUM) begin
      if (class_end) begin
        class_scores[32'(class_cnt)*CNT_W +: CNT_W] <= acc_next;
        best_score <= win_score;
        best_idx   <= win_idx;
        best_valid <= 1'b1;
        acc        <= '0;
        chunk_cnt  <= '0;
        class_cnt  <= class_cnt + IDX_W'(1);
        if (run_end) begin
          answer    <= win_idx;
          max_score <= win_score;
          busy      <= 1'b0;
          done      <= 1'b1;
          class_cnt <= '0;
        end
      end else begin
        acc       <= acc_next;
        chunk_cnt <= chunk_cnt + CHK_W'(1);
      end
    end
  end

endmodule
